mux21_rr_arbiter: RTL and testbench
===================================

MUX21_RR_ARBITER -- requirements
Module: mux21_rr_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 4, giving the width of each requester data bus and of out_data.
REQ-002 The block SHALL have parameter CNT_WIDTH, default 7, giving the width of each grant counter.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset, input, 1, asynchronous, active-high reset.
REQ-005 The block SHALL have ports in0 and in1, input, DATA_WIDTH each, requester 0 and requester 1 data.
REQ-006 The block SHALL have ports in0_valid and in1_valid, input, 1 each, requester data valid.
REQ-007 The block SHALL have ports in0_ready and in1_ready, output, 1 each, requester accept strobes.
REQ-008 The block SHALL have port out_data, output, DATA_WIDTH, the registered muxed data.
REQ-009 The block SHALL have port out_valid, output, 1, which is high while out_data holds an unconsumed word.
REQ-010 The block SHALL have port out_ready, input, 1, the downstream accept strobe.
REQ-011 The block SHALL have port select, output, 1, the index of the requester most recently granted.
REQ-012 The block SHALL have ports count0 and count1, output, CNT_WIDTH each, the accepted-transfer totals per requester.

Function
REQ-013 The FSM SHALL have states EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-014 can_load SHALL equal (state==EMPTY) or out_ready.
REQ-015 Grant rule: with only one valid, that requester is granted; with both valid, the requester != select is granted (round-robin); with none valid, no grant.
REQ-016 Each ready output SHALL equal its grant AND can_load; at most one ready SHALL be high per cycle; ready SHALL not depend on the requester's own data.
REQ-017 A transfer SHALL occur when ready and valid are both high for requester k; on that edge out_data<=in_k, state->FULL, select<=k, and count_k increments by 1.
REQ-018 In FULL with out_ready=1 and no transfer, the next state SHALL be EMPTY and out_data SHALL hold its value.
REQ-019 In FULL with out_ready=1 and a transfer, the block SHALL stay FULL and load the new word in the same edge, sustaining one word per cycle.
REQ-020 In FULL with out_ready=0, state, out_data, select and counters SHALL hold, and both ready outputs SHALL be 0.
REQ-021 Latency SHALL be one cycle from the input transfer edge to out_valid/out_data.
REQ-022 Each counter SHALL wrap from 2^CNT_WIDTH-1 to 0 without affecting any other state.
REQ-023 A requester that deasserts valid before a transfer SHALL lose nothing; the grant SHALL be re-evaluated every cycle.

Reset
REQ-024 Asserting reset SHALL immediately force state=EMPTY, out_valid=0, out_data=0, select=1, count0=0 and count1=0, so requester 0 wins the first tie.
REQ-025 A word held in FULL when reset asserts mid-operation SHALL be discarded; while reset is high, in0_ready and in1_ready SHALL be 0.
REQ-026 The first transfer after reset SHALL be possible on the first rising clk edge after reset deasserts.

Structure
REQ-027 The shared package mux_pkg SHALL hold the FSM state typedef (EMPTY, FULL) and the default DATA_WIDTH/CNT_WIDTH constants.
REQ-028 The block SHALL contain one sub-module, rr_grant2, which is combinational and produces two one-hot grants from the two valid inputs and select.
REQ-029 The output register, the FSM and the counters SHALL reside in mux21_rr_arbiter.

Verification
REQ-030 Reset asserted mid-cycle while FULL with out_data=4'hA -> out_valid=0, out_data=0, select=1 and both counts=0 before the next edge.
REQ-031 in0_valid=1 with in0=4'h3, in1_valid=0, out_ready=1 -> in0_ready=1; next cycle out_data=3, out_valid=1, select=0, count0=1.
REQ-032 Both valid for 4 cycles (in0=5, in1=9), out_ready=1 -> out_data sequence 5,9,5,9 and count0=count1=2.
REQ-033 out_ready=0 while FULL for 3 cycles with both valid -> both readys=0; out_data, select and counts unchanged.
REQ-034 in1 alone streams 128 transfers -> count1 wraps to 0; count0 stays 0; no bubble in out_valid.
REQ-035 FULL, out_ready=1, no valid -> next cycle EMPTY, out_valid=0, out_data unchanged.

Source files
------------

// File: rtl/mux_pkg.sv
// Shared types and default widths for the two-requester round-robin mux.
package mux_pkg;
  localparam int unsigned DATA_WIDTH_DEF = 4;
  localparam int unsigned CNT_WIDTH_DEF  = 7;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;
endpackage

// File: rtl/rr_grant2.sv
// Combinational two-way round-robin grant: on a tie the requester that was
// not granted last time wins.
module rr_grant2 (
  input  logic valid0_i,
  input  logic valid1_i,
  input  logic select_i,
  output logic grant0_o,
  output logic grant1_o
);

  // One-hot grant from the valids and the last-granted index
  always_comb begin
    grant0_o = 1'b0;
    grant1_o = 1'b0;
    if (valid0_i && valid1_i) begin
      grant0_o = select_i;
      grant1_o = ~select_i;
    end else if (valid0_i) begin
      grant0_o = 1'b1;
    end else if (valid1_i) begin
      grant1_o = 1'b1;
    end else begin
      grant0_o = 1'b0;
      grant1_o = 1'b0;
    end
  end

endmodule

// File: rtl/mux21_rr_arbiter.sv
// 2:1 round-robin arbitrating mux with a single-entry registered output stage
// and per-requester accepted-transfer counters.
module mux21_rr_arbiter
  import mux_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned CNT_WIDTH  = CNT_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] in0,
  input  logic [DATA_WIDTH-1:0] in1,
  input  logic                  in0_valid,
  input  logic                  in1_valid,
  output logic                  in0_ready,
  output logic                  in1_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  select,
  output logic [CNT_WIDTH-1:0]  count0,
  output logic [CNT_WIDTH-1:0]  count1
);

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                  select_q, select_d;
  logic [CNT_WIDTH-1:0]  count0_q, count0_d;
  logic [CNT_WIDTH-1:0]  count1_q, count1_d;

  logic grant0_s, grant1_s;
  logic can_load_s;
  logic xfer0_s, xfer1_s;

  rr_grant2 u_grant (
    .valid0_i (in0_valid),
    .valid1_i (in1_valid),
    .select_i (select_q),
    .grant0_o (grant0_s),
    .grant1_o (grant1_s)
  );

  // Readies are masked by reset so nothing is accepted while it is held.
  assign can_load_s = (state_q == EMPTY) || out_ready;
  assign in0_ready  = grant0_s & can_load_s & ~reset;
  assign in1_ready  = grant1_s & can_load_s & ~reset;
  assign xfer0_s    = in0_ready & in0_valid;
  assign xfer1_s    = in1_ready & in1_valid;

  // Next-state: load on transfer, drain when consumed, otherwise hold
  always_comb begin
    state_d    = state_q;
    out_data_d = out_data_q;
    select_d   = select_q;
    count0_d   = count0_q;
    count1_d   = count1_q;
    if (xfer0_s) begin
      state_d    = FULL;
      out_data_d = in0;
      select_d   = 1'b0;
      count0_d   = count0_q + CNT_ONE;
    end else if (xfer1_s) begin
      state_d    = FULL;
      out_data_d = in1;
      select_d   = 1'b1;
      count1_d   = count1_q + CNT_ONE;
    end else if ((state_q == FULL) && out_ready) begin
      state_d = EMPTY;
    end else begin
      state_d = state_q;
    end
  end

  // State, output word, last grant and counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= EMPTY;
      out_data_q <= '0;
      select_q   <= 1'b1;
      count0_q   <= '0;
      count1_q   <= '0;
    end else begin
      state_q    <= state_d;
      out_data_q <= out_data_d;
      select_q   <= select_d;
      count0_q   <= count0_d;
      count1_q   <= count1_d;
    end
  end

  assign out_valid = (state_q == FULL);
  assign out_data  = out_data_q;
  assign select    = select_q;
  assign count0    = count0_q;
  assign count1    = count1_q;

endmodule

// File: tb/tb_mux21_rr_arbiter.sv
// Directed self-checking bench for mux21_rr_arbiter.
module tb_mux21_rr_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] in0, in1;
  logic       in0_valid, in1_valid;
  logic       in0_ready, in1_ready;
  logic [3:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       select;
  logic [6:0] count0, count1;

  int checks = 0;
  int errors = 0;

  mux21_rr_arbiter #(.DATA_WIDTH(4), .CNT_WIDTH(7)) dut (
    .clk       (clk),
    .reset     (reset),
    .in0       (in0),
    .in1       (in1),
    .in0_valid (in0_valid),
    .in1_valid (in1_valid),
    .in0_ready (in0_ready),
    .in1_ready (in1_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .select    (select),
    .count0    (count0),
    .count1    (count1)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input int v, input int d, input int s,
                           input int c0, input int c1);
    check({tag, "_valid"}, 32'(out_valid), 32'(v));
    check({tag, "_data"},  32'(out_data),  32'(d));
    check({tag, "_sel"},   32'(select),    32'(s));
    check({tag, "_cnt0"},  32'(count0),    32'(c0));
    check({tag, "_cnt1"},  32'(count1),    32'(c1));
  endtask

  task automatic check_rdy(input string tag, input int r0, input int r1);
    check({tag, "_rdy0"}, 32'(in0_ready), 32'(r0));
    check({tag, "_rdy1"}, 32'(in1_ready), 32'(r1));
  endtask

  logic [3:0] seq [4];

  initial begin
    reset = 1'b1; in0 = 4'h0; in1 = 4'h0;
    in0_valid = 1'b0; in1_valid = 1'b0; out_ready = 1'b0;
    tick(); tick();

    // Reset state, readies masked while reset is high
    in0_valid = 1'b1; in1_valid = 1'b1; #1;
    check_out("rst", 0, 0, 1, 0, 0);
    check_rdy("rst", 0, 0);

    // Single requester 0, first edge after reset release
    in1_valid = 1'b0; in0 = 4'h3; out_ready = 1'b1; reset = 1'b0; #1;
    check_rdy("single0", 1, 0);
    tick();
    check_out("single0", 1, 3, 0, 1, 0);

    // FULL, consumed, nothing valid -> EMPTY, data held
    in0_valid = 1'b0; #1;
    tick();
    check_out("drain", 0, 3, 0, 1, 0);

    // Load 4'hA, then reset mid-cycle while FULL
    in0 = 4'hA; in0_valid = 1'b1; #1;
    tick();
    check_out("loadA", 1, 10, 0, 2, 0);
    out_ready = 1'b0; in1_valid = 1'b1; #3;
    reset = 1'b1; #1;
    check_out("midrst", 0, 0, 1, 0, 0);
    check_rdy("midrst", 0, 0);
    tick();
    reset = 1'b0;

    // Both valid, round-robin 5,9,5,9 at one word per cycle
    in0 = 4'h5; in1 = 4'h9; in0_valid = 1'b1; in1_valid = 1'b1; out_ready = 1'b1; #1;
    check_rdy("rr_first", 1, 0);
    seq[0] = 4'h5; seq[1] = 4'h9; seq[2] = 4'h5; seq[3] = 4'h9;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("rr_valid", 32'(out_valid), 32'd1);
      check("rr_data",  32'(out_data),  32'(seq[i]));
      check("rr_sel",   32'(select),    32'(i % 2));
    end
    check("rr_cnt0", 32'(count0), 32'd2);
    check("rr_cnt1", 32'(count1), 32'd2);

    // Stall while FULL with both valid
    out_ready = 1'b0; #1;
    check_rdy("stall0", 0, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_rdy("stall", 0, 0);
      check_out("stall", 1, 9, 1, 2, 2);
    end

    // Fresh reset, then requester 1 streams 128 words: counter wraps to 0
    reset = 1'b1; #1;
    tick();
    reset = 1'b0; in0_valid = 1'b0; in1_valid = 1'b1; out_ready = 1'b1;
    for (int k = 1; k <= 128; k++) begin
      in1 = 4'(k); #1;
      check("stream_rdy1", 32'(in1_ready), 32'd1);
      tick();
      check("stream_valid", 32'(out_valid), 32'd1);
      check("stream_data",  32'(out_data),  32'(k % 16));
      check("stream_cnt1",  32'(count1),    32'(k % 128));
      check("stream_cnt0",  32'(count0),    32'd0);
    end
    in1_valid = 1'b0; #1;
    tick();
    check_out("stream_end", 0, 0, 1, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
